// File: rtl/gemm_pkg.sv
// Shared types for the GeMM writeback path: FSM states and the FIFO entry layout.
// The entry widths here fix the address/data widths used by gemm_writeback.
package gemm_pkg;

    localparam int WbAddrWidth = 16;
    localparam int WbDataWidth = 32;

    typedef enum logic [1:0] {
        WbIdle,
        WbActive,
        WbDrain,
        WbDone
    } wb_state_t;

    typedef struct packed {
        logic [WbAddrWidth-1:0] addr;
        logic [WbDataWidth-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/gemm_wb_fifo.sv
// Synchronous FIFO of writeback entries (address + data), power-of-two depth.
// Pointers wrap naturally; the occupancy counter carries one extra bit to tell full from empty.
module gemm_wb_fifo
    import gemm_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  wb_entry_t                din,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int PtrWidth   = $clog2(Depth);
    localparam int CountWidth = PtrWidth + 1;

    wb_entry_t            mem [Depth];
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CountWidth'(Depth));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CountWidth'(1);
                2'b01:   count <= count - CountWidth'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gemm_writeback.sv
// Writeback stage after the GeMM controller: buffers C elements and writes them row-major to memory.
// Optional feature macro GEMM_WB_PERF_EN adds the stall_cycles_o performance counter.
module gemm_writeback
    import gemm_pkg::*;
#(
    parameter int AddrWidth = WbAddrWidth,
    parameter int DataWidth = WbDataWidth,
    parameter int FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic [AddrWidth-1:0] c_base_addr_i,
    input  logic                 result_valid_i,
    input  logic [DataWidth-1:0] result_data_i,
    output logic                 stall_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o
`ifdef GEMM_WB_PERF_EN
    ,
    output logic [31:0]          stall_cycles_o
`endif
);

    localparam int CountWidth = $clog2(FifoDepth) + 1;

    wb_state_t              state;
    logic [AddrWidth-1:0]   m_size;
    logic [AddrWidth-1:0]   n_size;
    logic [AddrWidth-1:0]   m_idx;
    logic [AddrWidth-1:0]   n_idx;
    logic [AddrWidth-1:0]   row_base;
    logic                   start_ok;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic                   row_end;
    logic                   last_elem;
    logic [CountWidth-1:0]  count;
    wb_entry_t              push_entry;
    wb_entry_t              head;

    assign start_ok   = (state == WbIdle) && start_i;
    assign push       = result_valid_i && !full && (state == WbActive);
    assign pop        = !empty && mem_gnt_i;
    assign row_end    = (n_idx == n_size - AddrWidth'(1));
    assign last_elem  = row_end && (m_idx == m_size - AddrWidth'(1));
    assign push_entry = '{addr: row_base + n_idx, data: result_data_i};

    gemm_wb_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .din    (push_entry),
        .pop    (pop),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    // Head fields are forced to zero when nothing is queued so idle outputs never show stale data.
    assign stall_o     = full;
    assign mem_req_o   = !empty;
    assign mem_addr_o  = empty ? '0 : head.addr;
    assign mem_wdata_o = empty ? '0 : head.data;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= WbIdle;
            m_size     <= '0;
            n_size     <= '0;
            m_idx      <= '0;
            n_idx      <= '0;
            row_base   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                WbIdle: begin
                    if (start_i) begin
                        m_size     <= M_size_i;
                        n_size     <= N_size_i;
                        m_idx      <= '0;
                        n_idx      <= '0;
                        row_base   <= c_base_addr_i;
                        overflow_o <= 1'b0;
                        busy_o     <= 1'b1;
                        if ((M_size_i == '0) || (N_size_i == '0)) begin
                            state  <= WbDone;
                            done_o <= 1'b1;
                        end else begin
                            state  <= WbActive;
                        end
                    end
                end
                WbActive: begin
                    if (result_valid_i && full) begin
                        overflow_o <= 1'b1;
                    end
                    // Row-major walk: advancing the row base by N avoids an m*N multiply.
                    if (push) begin
                        if (row_end) begin
                            n_idx    <= '0;
                            m_idx    <= m_idx + AddrWidth'(1);
                            row_base <= row_base + n_size;
                        end else begin
                            n_idx    <= n_idx + AddrWidth'(1);
                        end
                        if (last_elem) begin
                            state <= WbDrain;
                        end
                    end
                end
                WbDrain: begin
                    if (empty || (pop && (count == CountWidth'(1)))) begin
                        state  <= WbDone;
                        done_o <= 1'b1;
                    end
                end
                WbDone: begin
                    state  <= WbIdle;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= WbIdle;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef GEMM_WB_PERF_EN
    // Counts cycles a write waits for a grant; holds at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cycles_o <= '0;
        end else if (start_ok) begin
            stall_cycles_o <= '0;
        end else if (mem_req_o && !mem_gnt_i && (stall_cycles_o != '1)) begin
            stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gemm_writeback.sv
// Bench for gemm_writeback: random data and grants, writes checked against a row-major address model.
// Expected writes go into a queue at acceptance; an independent monitor pops and compares on each grant.
module tb_gemm_writeback;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW-1:0] M_size_i;
    logic [AW-1:0] N_size_i;
    logic [AW-1:0] c_base_addr_i;
    logic          result_valid_i;
    logic [DW-1:0] result_data_i;
    logic          stall_o;
    logic          mem_req_o;
    logic          mem_gnt_i;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          busy_o;
    logic          done_o;
    logic          overflow_o;
`ifdef GEMM_WB_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    exp_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            gnt_mode = 1;
    int            last_grant_cyc = -1;
    logic          prev_hold = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    gemm_writeback #(
        .AddrWidth (AW),
        .DataWidth (DW),
        .FifoDepth (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .M_size_i       (M_size_i),
        .N_size_i       (N_size_i),
        .c_base_addr_i  (c_base_addr_i),
        .result_valid_i (result_valid_i),
        .result_data_i  (result_data_i),
        .stall_o        (stall_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overflow_o     (overflow_o)
`ifdef GEMM_WB_PERF_EN
        ,
        .stall_cycles_o (stall_cycles)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    // Grant source: 0 = always grant, 1 = never grant, 2 = random grant.
    initial begin
        mem_gnt_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (gnt_mode)
                0:       mem_gnt_i = 1'b1;
                1:       mem_gnt_i = 1'b0;
                default: mem_gnt_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pop on every granted write, plus hold-stability while waiting for a grant.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (prev_hold) begin
            checkOutput("req_held", {63'd0, mem_req_o}, 64'd1);
            checkOutput("addr_stable", {48'd0, mem_addr_o}, {48'd0, prev_addr});
            checkOutput("wdata_stable", {32'd0, mem_wdata_o}, {32'd0, prev_data});
        end
        if (rst_ni && mem_req_o && mem_gnt_i) begin
            if (exp_q.size() == 0) begin
                failNow($sformatf("unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                                  mem_addr_o, mem_wdata_o));
            end else begin
                e = exp_q.pop_front();
                checkOutput("write_addr", {48'd0, mem_addr_o}, {48'd0, e.addr});
                checkOutput("write_data", {32'd0, mem_wdata_o}, {32'd0, e.data});
            end
            last_grant_cyc = cyc;
        end
        prev_hold = rst_ni && mem_req_o && !mem_gnt_i;
        prev_addr = mem_addr_o;
        prev_data = mem_wdata_o;
    end

    // All main-flow tasks start and end one time unit after a rising edge.
    task automatic startJob(input logic [AW-1:0] m, input logic [AW-1:0] n, input logic [AW-1:0] base);
        start_i       = 1'b1;
        M_size_i      = m;
        N_size_i      = n;
        c_base_addr_i = base;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Feeds elements [first,last) of a row-major job; upstream holds a result while stalled.
    task automatic applyStimulus(input int n, input logic [AW-1:0] base, input int first, input int last);
        for (int i = first; i < last; i++) begin
            int   waited;
            bit   taken;
            exp_t e;
            waited = 0;
            taken  = 1'b0;
            result_valid_i = 1'b1;
            result_data_i  = $urandom;
            while (!taken) begin
                @(negedge clk_i);
                if (!stall_o) begin
                    e.addr = AW'(int'(base) + (i / n) * n + (i % n));
                    e.data = result_data_i;
                    exp_q.push_back(e);
                    taken = 1'b1;
                end
                @(posedge clk_i);
                #1;
                if (!taken) begin
                    waited++;
                    if (waited > 200) begin
                        failNow("accept_timeout");
                        result_valid_i = 1'b0;
                        return;
                    end
                end
            end
        end
        result_valid_i = 1'b0;
    endtask

    task automatic waitQueueEmpty(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk_i);
            #1;
            guard++;
            if (guard > 500) begin
                failNow({tag, "_drain_timeout"});
                return;
            end
        end
    endtask

    task automatic waitJobDone(input string tag);
        int guard;
        guard = 0;
        forever begin
            @(negedge clk_i);
            if (done_o === 1'b1) break;
            guard++;
            if (guard > 500) begin
                failNow({tag, "_done_timeout"});
                @(posedge clk_i);
                #1;
                return;
            end
        end
        checkOutput({tag, "_done_after_last_grant"}, 64'(cyc), 64'(last_grant_cyc + 1));
        checkOutput({tag, "_all_written"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk_i);
        checkOutput({tag, "_done_one_cycle"}, {63'd0, done_o}, 64'd0);
        checkOutput({tag, "_idle_after_done"}, {63'd0, busy_o}, 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        exp_q.delete();
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] base;
        int            m;
        int            n;
        int            done_seen;

        rst_ni         = 1'b0;
        start_i        = 1'b0;
        M_size_i       = '0;
        N_size_i       = '0;
        c_base_addr_i  = '0;
        result_valid_i = 1'b0;
        result_data_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        @(negedge clk_i);
        checkOutput("reset_req", {63'd0, mem_req_o}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy_o}, 64'd0);
        checkOutput("reset_done", {63'd0, done_o}, 64'd0);
        checkOutput("reset_overflow", {63'd0, overflow_o}, 64'd0);
        checkOutput("reset_stall", {63'd0, stall_o}, 64'd0);
        checkOutput("reset_addr", {48'd0, mem_addr_o}, 64'd0);
        @(posedge clk_i);
        #1;

        $display("[TB] basic 2x3 job, grant always high");
        gnt_mode = 0;
        startJob(16'd2, 16'd3, 16'h0100);
        applyStimulus(3, 16'h0100, 0, 6);
        waitJobDone("basic");

        $display("[TB] 2x3 job with grant held low");
        gnt_mode = 1;
        @(posedge clk_i);
        #1;
        startJob(16'd2, 16'd3, 16'h0100);
        applyStimulus(3, 16'h0100, 0, 4);
        @(negedge clk_i);
        checkOutput("stall_after_4", {63'd0, stall_o}, 64'd1);
        checkOutput("no_overflow_yet", {63'd0, overflow_o}, 64'd0);
        @(posedge clk_i);
        #1;
        result_valid_i = 1'b1;
        result_data_i  = 32'hDEAD_BEEF;
        @(posedge clk_i);
        #1;
        result_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("overflow_set", {63'd0, overflow_o}, 64'd1);
        @(posedge clk_i);
        #1;
        gnt_mode = 0;
        waitQueueEmpty("held");
        done_seen = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (done_o) done_seen++;
        end
        checkOutput("held_no_done", 64'(done_seen), 64'd0);
        checkOutput("held_still_busy", {63'd0, busy_o}, 64'd1);
        checkOutput("held_overflow_sticky", {63'd0, overflow_o}, 64'd1);
        @(posedge clk_i);
        #1;
        doReset();
        @(negedge clk_i);
        checkOutput("reset_clears_overflow", {63'd0, overflow_o}, 64'd0);
        checkOutput("reset_clears_busy", {63'd0, busy_o}, 64'd0);
        @(posedge clk_i);
        #1;

        $display("[TB] results in Idle are ignored");
        result_valid_i = 1'b1;
        result_data_i  = $urandom;
        repeat (2) @(posedge clk_i);
        #1;
        result_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("idle_no_overflow", {63'd0, overflow_o}, 64'd0);
        checkOutput("idle_no_req", {63'd0, mem_req_o}, 64'd0);
        @(posedge clk_i);
        #1;

        $display("[TB] 3x4 job, random grants");
        gnt_mode = 2;
        base = AW'($urandom);
        startJob(16'd3, 16'd4, base);
        applyStimulus(4, base, 0, 12);
        waitJobDone("rand34");

        $display("[TB] empty job M=0 N=5");
        gnt_mode = 0;
        startJob(16'd0, 16'd5, 16'h0010);
        @(negedge clk_i);
        checkOutput("zero_busy", {63'd0, busy_o}, 64'd1);
        checkOutput("zero_done", {63'd0, done_o}, 64'd1);
        checkOutput("zero_no_req", {63'd0, mem_req_o}, 64'd0);
        @(negedge clk_i);
        checkOutput("zero_idle", {63'd0, busy_o}, 64'd0);
        checkOutput("zero_done_pulse", {63'd0, done_o}, 64'd0);
        checkOutput("zero_still_no_req", {63'd0, mem_req_o}, 64'd0);
        @(posedge clk_i);
        #1;

        $display("[TB] address wrap at top of memory");
        gnt_mode = 2;
        startJob(16'd1, 16'd4, 16'hFFFE);
        applyStimulus(4, 16'hFFFE, 0, 4);
        waitJobDone("wrap");

        $display("[TB] reset in the middle of a job");
        gnt_mode = 1;
        @(posedge clk_i);
        #1;
        startJob(16'd3, 16'd3, 16'h0040);
        applyStimulus(3, 16'h0040, 0, 2);
        @(negedge clk_i);
        checkOutput("mid_req_pending", {63'd0, mem_req_o}, 64'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        exp_q.delete();
        @(negedge clk_i);
        checkOutput("mid_reset_req", {63'd0, mem_req_o}, 64'd0);
        checkOutput("mid_reset_busy", {63'd0, busy_o}, 64'd0);
        checkOutput("mid_reset_overflow", {63'd0, overflow_o}, 64'd0);
        checkOutput("mid_reset_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        gnt_mode = 2;
        startJob(16'd2, 16'd2, 16'h0200);
        applyStimulus(2, 16'h0200, 0, 4);
        waitJobDone("after_reset");

        $display("[TB] random jobs");
        for (int j = 0; j < 3; j++) begin
            m    = $urandom_range(1, 4);
            n    = $urandom_range(1, 4);
            base = AW'($urandom);
            startJob(AW'(m), AW'(n), base);
            applyStimulus(n, base, 0, m * n);
            waitJobDone($sformatf("randjob%0d", j));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
